// File: rtl/step_run_controller.sv
// Step/run controller: turns raw DE2 key and switch inputs into a clean one-cycle
// processor step enable, either one step per key press or periodic run-mode steps.

module step_run_debounce #(
    parameter int CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean
);
    localparam int W = $clog2(CYCLES + 1);
    localparam logic [W-1:0] CNT_TC = W'(CYCLES - 1);

    logic         s1;
    logic         s2;
    logic [W-1:0] cnt;

    // Any sample that agrees with the clean level restarts the stability count.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            clean <= 1'b0;
            cnt   <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == clean) begin
                cnt <= '0;
            end else if (cnt == CNT_TC) begin
                clean <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module step_run_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 25000000
) (
    input  logic        CLOCK_50,
    input  logic        Reset,
    input  logic        StepKey_n,
    input  logic        RunSw,
    input  logic        Halt,
    output logic        StepPulse,
    output logic        Running,
    output logic        Halted,
    output logic [15:0] StepCount,
    output logic        KeyClean
);
    // state  | meaning
    // IDLE   | single-step mode, one pulse per debounced key press
    // RUN    | free-running, one pulse every RUN_DIV cycles
    // HALTED | processor reported halt, no pulses until Halt drops
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    localparam int RW = $clog2(RUN_DIV);
    localparam logic [RW-1:0] RATE_TC = RW'(RUN_DIV - 1);

    state_t        state;
    state_t        state_next;
    logic          key_clean;
    logic          run_clean;
    logic          key_prev;
    logic          press_evt;
    logic [RW-1:0] rate;
    logic [15:0]   step_count;
    logic          step_pulse;
    logic          running;
    logic          halted;

    // Key is inverted ahead of the synchronizer so reset means "not pressed".
    step_run_debounce #(.CYCLES(DEBOUNCE_CYCLES)) key_db (
        .clk   (CLOCK_50),
        .reset (Reset),
        .raw   (~StepKey_n),
        .clean (key_clean)
    );

    step_run_debounce #(.CYCLES(DEBOUNCE_CYCLES)) run_db (
        .clk   (CLOCK_50),
        .reset (Reset),
        .raw   (RunSw),
        .clean (run_clean)
    );

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            key_prev  <= 1'b0;
            press_evt <= 1'b0;
        end else begin
            key_prev  <= key_clean;
            press_evt <= key_clean & ~key_prev;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (Halt) begin
                    state_next = HALTED;
                end else if (run_clean) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (Halt) begin
                    state_next = HALTED;
                end else if (!run_clean) begin
                    state_next = IDLE;
                end
            end
            HALTED: begin
                if (!Halt) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Halt wins over a coincident press or terminal count; reset suppresses any pulse.
    always_comb begin
        step_pulse = 1'b0;
        running    = 1'b0;
        halted     = 1'b0;
        case (state)
            IDLE:    step_pulse = press_evt & ~Halt & ~Reset;
            RUN: begin
                running    = 1'b1;
                step_pulse = (rate == RATE_TC) & ~Halt & ~Reset;
            end
            HALTED:  halted = 1'b1;
            default: step_pulse = 1'b0;
        endcase
    end

    // Held at zero outside RUN so every entry starts a full period.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            rate <= '0;
        end else if (state == RUN && rate != RATE_TC) begin
            rate <= rate + 1'b1;
        end else begin
            rate <= '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            step_count <= 16'h0000;
        end else if (step_pulse) begin
            step_count <= step_count + 16'h0001;
        end
    end

    assign StepPulse = step_pulse;
    assign Running   = running;
    assign Halted    = halted;
    assign StepCount = step_count;
    assign KeyClean  = key_clean;
endmodule

// File: tb/tb_step_run_controller.sv
// Directed bench for step_run_controller with DEBOUNCE_CYCLES=4, RUN_DIV=8.
// Expected edge numbers are hand-derived from the key/run latency rules.

module tb_step_run_controller;
    localparam int DB = 4;
    localparam int RD = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_n;
    logic        run_sw;
    logic        halt;
    logic        step_pulse;
    logic        running;
    logic        halted;
    logic [15:0] step_count;
    logic        key_clean;

    int errors = 0;
    int checks = 0;

    step_run_controller #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(RD)) dut (
        .CLOCK_50  (clk),
        .Reset     (rst),
        .StepKey_n (key_n),
        .RunSw     (run_sw),
        .Halt      (halt),
        .StepPulse (step_pulse),
        .Running   (running),
        .Halted    (halted),
        .StepCount (step_count),
        .KeyClean  (key_clean)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Press just before edge 1; pulse expected only after edge 1+2+DB = 7.
    task automatic press_key(input logic exp_pulse, input string name);
        logic exp;
        key_n = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            tick();
            exp = exp_pulse && (j == 3 + DB);
            checks++;
            if (step_pulse !== exp) begin
                errors++;
                $display("FAIL %s press edge %0d: pulse=%b expected %b", name, j, step_pulse, exp);
            end
            checks++;
            if (key_clean !== (j >= 2 + DB)) begin
                errors++;
                $display("FAIL %s key_clean edge %0d: got %b expected %b", name, j, key_clean, (j >= 2 + DB));
            end
        end
        key_n = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            tick();
            checks++;
            if (step_pulse !== 1'b0) begin
                errors++;
                $display("FAIL %s release edge %0d: pulse=%b expected 0", name, j, step_pulse);
            end
        end
        checks++;
        if (key_clean !== 1'b0) begin
            errors++;
            $display("FAIL %s key_clean after release: got %b expected 0", name, key_clean);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; key_n = 1'b1; run_sw = 1'b0; halt = 1'b0;
        tick(); tick(); tick();
        checks++;
        if ({step_pulse, running, halted, key_clean} !== 4'b0000) begin
            errors++;
            $display("FAIL reset flags: got %b expected 0000", {step_pulse, running, halted, key_clean});
        end
        checks++;
        if (step_count !== 16'h0000) begin
            errors++;
            $display("FAIL reset count: got %h expected 0000", step_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_clean_press();
        press_key(1'b1, "clean");
        checks++;
        if (step_count !== 16'd1) begin
            errors++;
            $display("FAIL clean count: got %0d expected 1", step_count);
        end
    endtask

    task automatic test_bounce();
        logic [11:0] pat;
        pat = 12'b0001_0001_1111;
        for (int j = 11; j >= 0; j--) begin
            key_n = pat[j];
            tick();
            checks++;
            if (step_pulse !== 1'b0 || key_clean !== 1'b0) begin
                errors++;
                $display("FAIL bounce step %0d: pulse=%b key_clean=%b expected 0 0", 11 - j, step_pulse, key_clean);
            end
        end
        checks++;
        if (step_count !== 16'd1) begin
            errors++;
            $display("FAIL bounce count: got %0d expected 1", step_count);
        end
    endtask

    // Clean run rises after edge 6, RUN entered at edge 7, pulses after 14,22,30,38,46.
    task automatic test_run_mode();
        logic exp_p;
        do_reset();
        run_sw = 1'b1;
        for (int j = 1; j <= 47; j++) begin
            tick();
            exp_p = (j >= 14) && ((j - 14) % RD == 0);
            checks++;
            if (step_pulse !== exp_p || running !== (j >= 7)) begin
                errors++;
                $display("FAIL run edge %0d: pulse=%b running=%b expected %b %b", j, step_pulse, running, exp_p, (j >= 7));
            end
        end
        checks++;
        if (step_count !== 16'd5) begin
            errors++;
            $display("FAIL run count: got %0d expected 5", step_count);
        end
        // Switch drops before edge 48: clean falls after 53, IDLE after 54.
        run_sw = 1'b0;
        for (int j = 48; j <= 70; j++) begin
            tick();
            checks++;
            if (step_pulse !== 1'b0 || running !== (j < 54)) begin
                errors++;
                $display("FAIL run stop edge %0d: pulse=%b running=%b expected 0 %b", j, step_pulse, running, (j < 54));
            end
        end
        checks++;
        if (step_count !== 16'd5) begin
            errors++;
            $display("FAIL run stop count: got %0d expected 5", step_count);
        end
    endtask

    task automatic test_halt();
        do_reset();
        run_sw = 1'b1;
        for (int j = 1; j <= 14; j++) tick();
        checks++;
        if (step_pulse !== 1'b1) begin
            errors++;
            $display("FAIL halt pre-tc: pulse=%b expected 1", step_pulse);
        end
        halt = 1'b1;
        #1;
        checks++;
        if (step_pulse !== 1'b0) begin
            errors++;
            $display("FAIL halt on tc: pulse=%b expected 0", step_pulse);
        end
        tick();
        checks++;
        if (halted !== 1'b1 || running !== 1'b0 || step_count !== 16'd0) begin
            errors++;
            $display("FAIL halt state: halted=%b running=%b count=%0d expected 1 0 0", halted, running, step_count);
        end
        run_sw = 1'b0;
        press_key(1'b0, "halted");
        halt = 1'b0;
        tick();
        checks++;
        if (halted !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL unhalt: halted=%b running=%b expected 0 0", halted, running);
        end
        press_key(1'b1, "after_halt");
        checks++;
        if (step_count !== 16'd1) begin
            errors++;
            $display("FAIL after halt count: got %0d expected 1", step_count);
        end
    endtask

    // Reset at edge 13 (rate=5); run re-syncs, RUN at 20, pulses after 27 and 35.
    task automatic test_reset_mid_run();
        logic exp_p;
        do_reset();
        run_sw = 1'b1;
        for (int j = 1; j <= 12; j++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({step_pulse, running, halted, key_clean} !== 4'b0000 || step_count !== 16'd0) begin
            errors++;
            $display("FAIL mid-run reset: flags=%b count=%0d expected 0000 0", {step_pulse, running, halted, key_clean}, step_count);
        end
        rst = 1'b0;
        for (int j = 14; j <= 36; j++) begin
            tick();
            exp_p = (j == 27) || (j == 35);
            checks++;
            if (step_pulse !== exp_p || running !== (j >= 20)) begin
                errors++;
                $display("FAIL rerun edge %0d: pulse=%b running=%b expected %b %b", j, step_pulse, running, exp_p, (j >= 20));
            end
        end
        checks++;
        if (step_count !== 16'd2) begin
            errors++;
            $display("FAIL rerun count: got %0d expected 2", step_count);
        end
    endtask

    task automatic test_wrap();
        run_sw = 1'b0;
        do_reset();
        @(negedge clk);
        force dut.step_count = 16'hFFFE;
        #1;
        release dut.step_count;
        #1;
        checks++;
        if (step_count !== 16'hFFFE) begin
            errors++;
            $display("FAIL wrap preset: got %h expected fffe", step_count);
        end
        tick();
        press_key(1'b1, "wrap1");
        checks++;
        if (step_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap ffff: got %h expected ffff", step_count);
        end
        press_key(1'b1, "wrap2");
        checks++;
        if (step_count !== 16'h0000) begin
            errors++;
            $display("FAIL wrap zero: got %h expected 0000", step_count);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_run_mode();
        test_halt();
        test_reset_mid_run();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
